// File: rtl/activation_feeder.sv
// activation_feeder: read-side sequencer around the activation unit.
// Streams `length` accumulator rows into the activation unit. It then
// re-times the byte results against a delayed write pointer and writes
// them to the unified buffer.
// Optional cycle counter on perf_cycles: define FEEDER_PERF_CNT_EN.
// Handshake: there is none. `start` is a one-cycle strobe that is accepted
// only in IDLE. Reads are fire-and-forget, with data one cycle later. Each
// buf_write_en cycle carries exactly one row.

package activation_feeder_pkg;
   typedef logic [31:0] word_type;
   typedef logic [7:0]  byte_type;
   typedef enum logic [3:0] {
      no_activation = 4'd0,
      relu          = 4'd1,
      relu6         = 4'd2,
      crelu         = 4'd3,
      elu           = 4'd4,
      selu          = 4'd5,
      softsign      = 4'd6,
      softplus      = 4'd7,
      sigmoid       = 4'd8
   } activation_type;
endpackage

module activation_feeder
   import activation_feeder_pkg::*;
#(
   parameter int MATRIX_WIDTH      = 14,
   parameter int ACC_ADDR_WIDTH    = 16,
   parameter int BUFFER_ADDR_WIDTH = 24,
   parameter int LENGTH_WIDTH      = 16,
   parameter int ACT_LATENCY       = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [ACC_ADDR_WIDTH-1:0]             acc_start_addr,
   input  logic [BUFFER_ADDR_WIDTH-1:0]          buf_start_addr,
   input  logic [LENGTH_WIDTH-1:0]               length,
   input  activation_type                        activation_function_in,
   input  logic                                  is_signed_in,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  acc_read_en,
   output logic [ACC_ADDR_WIDTH-1:0]             acc_read_addr,
   input  word_type [MATRIX_WIDTH-1:0]           acc_data,
   output logic                                  act_enable,
   output activation_type                        act_function,
   output logic                                  act_is_signed,
   output word_type [MATRIX_WIDTH-1:0]           act_data_in,
   input  byte_type [MATRIX_WIDTH-1:0]           act_data_out,
   output logic                                  buf_write_en,
   output logic [BUFFER_ADDR_WIDTH-1:0]          buf_write_addr,
   output byte_type [MATRIX_WIDTH-1:0]           buf_write_data,
   output logic [31:0]                           perf_cycles,
   output logic [1:0]                            dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t                          state_q, state_d;
   logic                            accept;
   logic [ACC_ADDR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LENGTH_WIDTH-1:0]         rows_left_q, rows_left_d;
   logic [BUFFER_ADDR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
   activation_type                  func_q, func_d;
   logic                            signed_q, signed_d;
   // valid_q[k] marks a read issued k+1 cycles ago; the top bit lines up
   // with the activation unit's valid output.
   logic [ACT_LATENCY:0]            valid_q, valid_d;
   logic                            buf_we_q, buf_we_d;
   logic [BUFFER_ADDR_WIDTH-1:0]    buf_addr_q, buf_addr_d;
   byte_type [MATRIX_WIDTH-1:0]     buf_data_q, buf_data_d;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic and per-state strobes.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      acc_read_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (length == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            busy        = 1'b1;
            acc_read_en = 1'b1;
            if (rows_left_q == LENGTH_WIDTH'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // The final row is already in the output register once the
            // valid pipe empties, so FINISH follows the last write.
            if (valid_q == '0) state_d = FINISH;
         end
         FINISH: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: command latch, read counter, write pointer, output row.
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      rows_left_d = rows_left_q;
      wr_ptr_d    = wr_ptr_q;
      func_d      = func_q;
      signed_d    = signed_q;
      valid_d     = {valid_q[ACT_LATENCY-1:0], acc_read_en};
      buf_we_d    = valid_q[ACT_LATENCY];
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (accept) begin
         rd_ptr_d    = acc_start_addr;
         rows_left_d = length;
         wr_ptr_d    = buf_start_addr;
         func_d      = activation_function_in;
         signed_d    = is_signed_in;
      end
      if (acc_read_en) begin
         rd_ptr_d    = rd_ptr_q + ACC_ADDR_WIDTH'(1);
         rows_left_d = rows_left_q - LENGTH_WIDTH'(1);
      end
      if (valid_q[ACT_LATENCY]) begin
         buf_addr_d = wr_ptr_q;
         buf_data_d = act_data_out;
         wr_ptr_d   = wr_ptr_q + BUFFER_ADDR_WIDTH'(1);
      end
   end

   // Datapath registers; reset drops any rows still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q    <= '0;
         rows_left_q <= '0;
         wr_ptr_q    <= '0;
         func_q      <= no_activation;
         signed_q    <= 1'b0;
         valid_q     <= '0;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         rows_left_q <= rows_left_d;
         wr_ptr_q    <= wr_ptr_d;
         func_q      <= func_d;
         signed_q    <= signed_d;
         valid_q     <= valid_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
      end
   end

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   // Counts ISSUE and DRAIN cycles, so it ends at length + ACT_LATENCY + 2.
   always_comb begin
      perf_d = perf_q;
      if (accept)                                    perf_d = '0;
      else if (state_q == ISSUE || state_q == DRAIN) perf_d = perf_q + 32'd1;
   end

   // Performance counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_q <= '0;
      else      perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

   assign acc_read_addr  = acc_read_en ? rd_ptr_q : '0;
   assign act_enable     = busy;
   assign act_function   = func_q;
   assign act_is_signed  = signed_q;
   assign act_data_in    = acc_data;
   assign buf_write_en   = buf_we_q;
   assign buf_write_addr = buf_addr_q;
   assign buf_write_data = buf_data_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_activation_feeder.sv
// Bench for activation_feeder. It uses a behavioural accumulator memory
// with one-cycle read latency. It also uses a 3-stage activation stand-in
// that maps each word to one byte: the low byte XOR {signed, function}.
module tb_activation_feeder;
  import activation_feeder_pkg::*;

  localparam int MW   = 4;
  localparam int AAW  = 16;
  localparam int BAW  = 24;
  localparam int LW   = 16;
  localparam int ACTL = 3;

  typedef word_type [MW-1:0] row_w_t;
  typedef byte_type [MW-1:0] row_b_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic           start = 1'b0;
  logic [AAW-1:0] acc_start_addr = '0;
  logic [BAW-1:0] buf_start_addr = '0;
  logic [LW-1:0]  length = '0;
  activation_type activation_function_in = no_activation;
  logic           is_signed_in = 1'b0;
  logic           busy, done, acc_read_en, act_enable, act_is_signed, buf_write_en;
  logic [AAW-1:0] acc_read_addr;
  row_w_t         acc_data = '0;
  row_w_t         act_data_in;
  row_b_t         act_data_out;
  activation_type act_function;
  logic [BAW-1:0] buf_write_addr;
  row_b_t         buf_write_data;
  logic [31:0]    perf_cycles;
  logic [1:0]     dbg_state;

  activation_feeder #(
    .MATRIX_WIDTH(MW), .ACC_ADDR_WIDTH(AAW), .BUFFER_ADDR_WIDTH(BAW),
    .LENGTH_WIDTH(LW), .ACT_LATENCY(ACTL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .acc_start_addr(acc_start_addr), .buf_start_addr(buf_start_addr),
    .length(length), .activation_function_in(activation_function_in),
    .is_signed_in(is_signed_in), .busy(busy), .done(done),
    .acc_read_en(acc_read_en), .acc_read_addr(acc_read_addr),
    .acc_data(acc_data), .act_enable(act_enable), .act_function(act_function),
    .act_is_signed(act_is_signed), .act_data_in(act_data_in),
    .act_data_out(act_data_out), .buf_write_en(buf_write_en),
    .buf_write_addr(buf_write_addr), .buf_write_data(buf_write_data),
    .perf_cycles(perf_cycles), .dbg_state(dbg_state)
  );

  // ---------------- environment models ----------------
  function automatic row_w_t mem_row(input logic [AAW-1:0] a);
    row_w_t r;
    for (int i = 0; i < MW; i++) r[i] = {a, 8'(i), a[7:0] + 8'(i)};
    return r;
  endfunction

  function automatic row_b_t stub_f(input row_w_t w, input activation_type f, input logic s);
    row_b_t r;
    for (int i = 0; i < MW; i++) r[i] = w[i][7:0] ^ {3'b000, s, f};
    return r;
  endfunction

  // Expected byte row for the row read from accumulator address a.
  function automatic row_b_t exp_row(input logic [AAW-1:0] a, input activation_type f, input logic s);
    row_b_t r;
    for (int i = 0; i < MW; i++) r[i] = (a[7:0] + 8'(i)) ^ {3'b000, s, f};
    return r;
  endfunction

  always @(posedge clk) if (acc_read_en) acc_data <= mem_row(acc_read_addr);

  row_b_t p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk)
    if (act_enable) begin
      p1 <= stub_f(act_data_in, act_function, act_is_signed);
      p2 <= p1;
      p3 <= p2;
    end
  assign act_data_out = p3;

  // ---------------- monitor ----------------
  logic [AAW-1:0] rd_addr_q[$];
  int             rd_cyc_q[$];
  logic [BAW-1:0] wr_addr_q[$];
  row_b_t         wr_data_q[$];
  int             wr_cyc_q[$];
  int             done_cyc_q[$];
  int             busy_cyc_q[$];
  logic [BAW-1:0] exp_q[$];
  row_b_t         exp_data_q[$];

  always @(negedge clk) begin
    if (acc_read_en)  begin rd_addr_q.push_back(acc_read_addr); rd_cyc_q.push_back(cyc); end
    if (buf_write_en) begin
      wr_addr_q.push_back(buf_write_addr);
      wr_data_q.push_back(buf_write_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (busy) busy_cyc_q.push_back(cyc);
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cyc;

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    #1;
    rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    wr_cyc_q.delete(); done_cyc_q.delete(); busy_cyc_q.delete();
    exp_q.delete(); exp_data_q.delete();
  endtask

  // Pulses start for one cycle; returns at the falling edge after acceptance.
  task automatic run_cmd(input logic [AAW-1:0] a, input logic [BAW-1:0] b,
                         input logic [LW-1:0] n, input activation_type f, input logic s);
    @(negedge clk);
    acc_start_addr = a; buf_start_addr = b; length = n;
    activation_function_in = f; is_signed_in = s; start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (done) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (acc_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", acc_read_en); end
    n_cmp++; if (buf_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", buf_write_en); end
    n_cmp++; if (buf_write_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", buf_write_addr); end
    n_cmp++; if (buf_write_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", buf_write_data); end
    n_cmp++; if (act_function !== no_activation) begin n_fail++; $display("FAIL reset_func: got %0d want 0", act_function); end
    n_cmp++; if (act_enable !== 1'b0) begin n_fail++; $display("FAIL reset_act_en: got %b want 0", act_enable); end
    n_cmp++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d want 0", perf_cycles); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    run_cmd(16'h0010, 24'h000200, 16'd1, sigmoid, 1'b1);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if (act_function !== sigmoid) begin n_fail++; $display("FAIL basic_func: got %0d want 8", act_function); end
    n_cmp++; if (act_is_signed !== 1'b1) begin n_fail++; $display("FAIL basic_signed: got %b want 1", act_is_signed); end
    wait_done(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout want done"); end
    n_cmp++; if (rd_addr_q.size() != 1) begin n_fail++; $display("FAIL basic_rd_cnt: got %0d want 1", rd_addr_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL basic_wr_cnt: got %0d want 1", wr_addr_q.size()); end
    if (rd_addr_q.size() >= 1 && wr_addr_q.size() >= 1) begin
      n_cmp++; if (rd_addr_q[0] !== 16'h0010) begin n_fail++; $display("FAIL basic_rd_addr: got %h want 0010", rd_addr_q[0]); end
      n_cmp++; if (wr_addr_q[0] !== 24'h000200) begin n_fail++; $display("FAIL basic_wr_addr: got %h want 000200", wr_addr_q[0]); end
      n_cmp++; if (wr_data_q[0] !== exp_row(16'h0010, sigmoid, 1'b1)) begin
        n_fail++; $display("FAIL basic_wr_data: got %h want %h", wr_data_q[0], exp_row(16'h0010, sigmoid, 1'b1)); end
      n_cmp++; if (wr_cyc_q[0] - rd_cyc_q[0] != 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", wr_cyc_q[0] - rd_cyc_q[0]); end
      if (done_cyc_q.size() >= 1) begin
        n_cmp++; if (done_cyc_q[0] != wr_cyc_q[0] + 1) begin n_fail++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc_q[0], wr_cyc_q[0] + 1); end
      end
    end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cyc_q.size()); end
    n_cmp++; if (busy_cyc_q.size() != 7) begin n_fail++; $display("FAIL basic_busy_len: got %0d want 7", busy_cyc_q.size()); end
`ifdef FEEDER_PERF_CNT_EN
    n_cmp++; if (perf_cycles !== 32'd6) begin n_fail++; $display("FAIL basic_perf: got %0d want 6", perf_cycles); end
`else
    n_cmp++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL basic_perf: got %0d want 0", perf_cycles); end
`endif
  endtask

  task automatic test_burst();
    bit to;
    clear_mon();
    run_cmd(16'h0000, 24'h000200, 16'd8, relu, 1'b0);
    wait_done(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL burst_timeout: got timeout want done"); end
    n_cmp++; if (rd_addr_q.size() != 8) begin n_fail++; $display("FAIL burst_rd_cnt: got %0d want 8", rd_addr_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 8) begin n_fail++; $display("FAIL burst_wr_cnt: got %0d want 8", wr_addr_q.size()); end
    for (int i = 0; i < 8; i++) begin exp_q.push_back(24'h000200 + BAW'(i)); exp_data_q.push_back(exp_row(AAW'(i), relu, 1'b0)); end
    for (int i = 0; i < wr_addr_q.size() && i < 8; i++) begin
      n_cmp++; if (wr_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL burst_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], exp_q[i]); end
      n_cmp++; if (wr_data_q[i] !== exp_data_q[i]) begin n_fail++; $display("FAIL burst_wr_data[%0d]: got %h want %h", i, wr_data_q[i], exp_data_q[i]); end
      n_cmp++; if (wr_cyc_q[i] != wr_cyc_q[0] + i) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d want %0d", i, wr_cyc_q[i], wr_cyc_q[0] + i); end
    end
    if (rd_cyc_q.size() >= 1 && wr_cyc_q.size() >= 8 && done_cyc_q.size() >= 1) begin
      n_cmp++; if (wr_cyc_q[0] - rd_cyc_q[0] != 5) begin n_fail++; $display("FAIL burst_latency: got %0d want 5", wr_cyc_q[0] - rd_cyc_q[0]); end
      n_cmp++; if (done_cyc_q[0] != wr_cyc_q[7] + 1) begin n_fail++; $display("FAIL burst_done_cyc: got %0d want %0d", done_cyc_q[0], wr_cyc_q[7] + 1); end
    end
    n_cmp++; if (busy_cyc_q.size() != 14) begin n_fail++; $display("FAIL burst_busy_len: got %0d want 14", busy_cyc_q.size()); end
`ifdef FEEDER_PERF_CNT_EN
    n_cmp++; if (perf_cycles !== 32'd13) begin n_fail++; $display("FAIL burst_perf: got %0d want 13", perf_cycles); end
`endif
  endtask

  task automatic test_zero_length();
    bit to;
    clear_mon();
    run_cmd(16'h0055, 24'h000066, 16'd0, relu6, 1'b1);
    wait_done(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL zero_timeout: got timeout want done"); end
    n_cmp++; if (rd_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_rd_cnt: got %0d want 0", rd_addr_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL zero_wr_cnt: got %0d want 0", wr_addr_q.size()); end
    n_cmp++; if (busy_cyc_q.size() != 1) begin n_fail++; $display("FAIL zero_busy_len: got %0d want 1", busy_cyc_q.size()); end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d want 1", done_cyc_q.size()); end
    if (done_cyc_q.size() >= 1) begin
      n_cmp++; if (done_cyc_q[0] != start_cyc + 1) begin n_fail++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc_q[0], start_cyc + 1); end
    end
    n_cmp++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL zero_perf: got %0d want 0", perf_cycles); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    clear_mon();
    run_cmd(16'h0040, 24'h000300, 16'd4, elu, 1'b1);
    @(negedge clk);
    acc_start_addr = 16'h0080; buf_start_addr = 24'h000500; length = 16'd2;
    activation_function_in = softplus; is_signed_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++; if (act_function !== elu) begin n_fail++; $display("FAIL swb_func: got %0d want 4", act_function); end
    n_cmp++; if (act_is_signed !== 1'b1) begin n_fail++; $display("FAIL swb_signed: got %b want 1", act_is_signed); end
    wait_done(to);
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (to) begin n_fail++; $display("FAIL swb_timeout: got timeout want done"); end
    n_cmp++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL swb_wr_cnt: got %0d want 4", wr_addr_q.size()); end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL swb_done_cnt: got %0d want 1", done_cyc_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
      n_cmp++; if (rd_addr_q[i] !== 16'h0040 + AAW'(i)) begin n_fail++; $display("FAIL swb_rd_addr[%0d]: got %h want %h", i, rd_addr_q[i], 16'h0040 + AAW'(i)); end
      n_cmp++; if (wr_addr_q[i] !== 24'h000300 + BAW'(i)) begin n_fail++; $display("FAIL swb_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], 24'h000300 + BAW'(i)); end
      n_cmp++; if (wr_data_q[i] !== exp_row(16'h0040 + AAW'(i), elu, 1'b1)) begin
        n_fail++; $display("FAIL swb_wr_data[%0d]: got %h want %h", i, wr_data_q[i], exp_row(16'h0040 + AAW'(i), elu, 1'b1)); end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [AAW-1:0] ra[3];
    logic [BAW-1:0] wa[3];
    ra[0] = 16'hFFFE; ra[1] = 16'hFFFF; ra[2] = 16'h0000;
    wa[0] = 24'hFFFFFF; wa[1] = 24'h000000; wa[2] = 24'h000001;
    clear_mon();
    run_cmd(16'hFFFE, 24'hFFFFFF, 16'd3, crelu, 1'b0);
    wait_done(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL wrap_timeout: got timeout want done"); end
    n_cmp++; if (rd_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_rd_cnt: got %0d want 3", rd_addr_q.size()); end
    n_cmp++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL wrap_wr_cnt: got %0d want 3", wr_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 3; i++) begin
      n_cmp++; if (rd_addr_q[i] !== ra[i]) begin n_fail++; $display("FAIL wrap_rd_addr[%0d]: got %h want %h", i, rd_addr_q[i], ra[i]); end
    end
    for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
      n_cmp++; if (wr_addr_q[i] !== wa[i]) begin n_fail++; $display("FAIL wrap_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], wa[i]); end
      n_cmp++; if (wr_data_q[i] !== exp_row(ra[i], crelu, 1'b0)) begin
        n_fail++; $display("FAIL wrap_wr_data[%0d]: got %h want %h", i, wr_data_q[i], exp_row(ra[i], crelu, 1'b0)); end
    end
  endtask

  task automatic test_reset_mid_command();
    bit to;
    clear_mon();
    run_cmd(16'h0020, 24'h000400, 16'd4, relu, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL rmid_in_drain: got %0d want 2", dbg_state); end
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (acc_read_en !== 1'b0) begin n_fail++; $display("FAIL rmid_rd_en: got %b want 0", acc_read_en); end
    n_cmp++; if (buf_write_en !== 1'b0) begin n_fail++; $display("FAIL rmid_wr_en: got %b want 0", buf_write_en); end
    n_cmp++; if (act_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_act_en: got %b want 0", act_enable); end
    n_cmp++; if (buf_write_addr !== '0) begin n_fail++; $display("FAIL rmid_wr_addr: got %h want 0", buf_write_addr); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    clear_mon();
    repeat (12) @(negedge clk);
    #1;
    n_cmp++; if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL rmid_stale_wr: got %0d want 0", wr_addr_q.size()); end
    n_cmp++; if (done_cyc_q.size() != 0) begin n_fail++; $display("FAIL rmid_stale_done: got %0d want 0", done_cyc_q.size()); end
    clear_mon();
    run_cmd(16'h0030, 24'h000600, 16'd4, selu, 1'b1);
    wait_done(to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL rmid_timeout: got timeout want done"); end
    n_cmp++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL rmid_wr_cnt: got %0d want 4", wr_addr_q.size()); end
    n_cmp++; if (done_cyc_q.size() != 1) begin n_fail++; $display("FAIL rmid_done_cnt: got %0d want 1", done_cyc_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
      n_cmp++; if (wr_addr_q[i] !== 24'h000600 + BAW'(i)) begin n_fail++; $display("FAIL rmid_wr_addr[%0d]: got %h want %h", i, wr_addr_q[i], 24'h000600 + BAW'(i)); end
      n_cmp++; if (wr_data_q[i] !== exp_row(16'h0030 + AAW'(i), selu, 1'b1)) begin
        n_fail++; $display("FAIL rmid_wr_data[%0d]: got %h want %h", i, wr_data_q[i], exp_row(16'h0030 + AAW'(i), selu, 1'b1)); end
    end
`ifdef FEEDER_PERF_CNT_EN
    n_cmp++; if (perf_cycles !== 32'd9) begin n_fail++; $display("FAIL rmid_perf: got %0d want 9", perf_cycles); end
`else
    n_cmp++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL rmid_perf: got %0d want 0", perf_cycles); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_zero_length();
    test_start_while_busy();
    test_wrap();
    test_reset_mid_command();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
